// File: rtl/valu_issue_pkg.sv
// Shared types, sizes and helpers for the vector ALU issue/writeback front end.
// Contents: lane geometry, bus payload typedefs, FSM state enum, result-buffer
// entry struct, and the per-lane pixel clamp function.
package valu_pkg;

   localparam int unsigned LANES = 3;
   localparam int unsigned W     = 18;
   localparam int unsigned OPW   = 3;
   localparam int unsigned TAGW  = 4;
   localparam int unsigned PIXW  = 8;
   localparam int unsigned CNTW  = 3;

   typedef logic [LANES-1:0][W-1:0]    vec_t;
   typedef logic [3:0]                 flags_t;
   typedef logic [OPW-1:0]             op_t;
   typedef logic [TAGW-1:0]            tag_t;
   typedef logic [LANES-1:0][PIXW-1:0] pixvec_t;

   typedef enum logic {
      IDLE = 1'b0,
      EXEC = 1'b1
   } state_t;

   typedef struct packed {
      vec_t   data;
      flags_t flags;
      tag_t   tag;
   } res_entry_t;

   // Signed lane to 0..255: negative -> 0, any bit above 7 set -> 255.
   function automatic logic [PIXW-1:0] clamp_pixel(input logic [W-1:0] lane);
      logic [PIXW-1:0] pix;
      if (lane[W-1]) begin
         pix = '0;
      end else if (|lane[W-2:PIXW]) begin
         pix = '1;
      end else begin
         pix = lane[PIXW-1:0];
      end
      return pix;
   endfunction

endpackage

// File: rtl/valu_issue_if.sv
// Bus interfaces of the vector ALU issue block.
//   valu_cmd_if : command port (valid/ready, operands, opcode, tag); slave = issue block
//   valu_alu_if : registered operands/opcode out, combinational result/flags back; master = issue block
//   valu_res_if : writeback port (valid/ready, data, pixels, flags, tag); master = issue block
interface valu_cmd_if;
   import valu_pkg::*;
   logic cmd_valid;
   logic cmd_ready;
   vec_t cmd_a;
   vec_t cmd_b;
   op_t  cmd_op;
   tag_t cmd_tag;

   modport master (output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag, input cmd_ready);
   modport slave  (input cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag, output cmd_ready);
endinterface

interface valu_alu_if;
   import valu_pkg::*;
   vec_t   alu_a;
   vec_t   alu_b;
   op_t    alu_op;
   vec_t   alu_result;
   flags_t alu_flags;

   modport master (output alu_a, alu_b, alu_op, input alu_result, alu_flags);
   modport slave  (input alu_a, alu_b, alu_op, output alu_result, alu_flags);
endinterface

interface valu_res_if;
   import valu_pkg::*;
   logic    res_valid;
   logic    res_ready;
   vec_t    res_data;
   pixvec_t res_pixel;
   flags_t  res_flags;
   tag_t    res_tag;

   modport master (output res_valid, res_data, res_pixel, res_flags, res_tag, input res_ready);
   modport slave  (input res_valid, res_data, res_pixel, res_flags, res_tag, output res_ready);
endinterface

// File: rtl/valu_issue_result_fifo.sv
// Two-entry result buffer holding {data, flags, tag}; 1-bit wrapping pointers.
// Ports: clk, reset (sync, active-low), i_push/i_data write side, i_pop/o_head
// read side, o_count/o_full/o_empty occupancy.
module valu_result_fifo
   import valu_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       i_push,
   input  res_entry_t i_data,
   input  logic       i_pop,
   output res_entry_t o_head,
   output logic [1:0] o_count,
   output logic       o_full,
   output logic       o_empty
);

   res_entry_t r_mem [2];
   logic       r_wr_ptr;
   logic       r_rd_ptr;
   logic [1:0] r_count;
   logic       w_push;
   logic       w_pop;

   assign w_push = i_push && (r_count != 2'd2);
   assign w_pop  = i_pop  && (r_count != 2'd0);

   // Storage is cleared on reset so the head reads zero while empty after reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_full  = (r_count == 2'd2);
   assign o_empty = (r_count == 2'd0);

endmodule

// File: rtl/valu_issue.sv
// Issue/writeback front end for the 3-lane x 18-bit vector ALU.
// Ports: clk, reset (sync, active-low); cmd (command valid/ready slave);
// alu (registered operands out, result/flags in); res (writeback valid/ready
// master with raw data, clamped pixels, flags, tag); busy (op in flight or
// buffer non-empty). SETTLE = cycles from operand load to result sampling (1..7).
module valu_issue
   import valu_pkg::*;
#(
   parameter int unsigned SETTLE = 1
) (
   input  logic       clk,
   input  logic       reset,
   valu_cmd_if.slave  cmd,
   valu_alu_if.master alu,
   valu_res_if.master res,
   output logic       busy
);

   state_t          r_state;
   state_t          w_next_state;
   logic [CNTW-1:0] r_settle;
   logic            r_live;
   vec_t            r_alu_a;
   vec_t            r_alu_b;
   op_t             r_alu_op;
   tag_t            r_tag;

   logic            w_ready;
   logic            w_accept;
   logic            w_sample;
   logic            w_pop;
   res_entry_t      w_push_data;
   res_entry_t      w_head;
   logic [1:0]      w_count;
   logic            w_full;
   logic            w_empty;

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next state: leave EXEC on the sampling edge
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next_state = EXEC;
         EXEC:    if (r_settle == '0) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // FSM outputs; r_live keeps cmd_ready low while reset is held
   always_comb begin
      w_ready  = 1'b0;
      w_accept = 1'b0;
      w_sample = 1'b0;
      case (r_state)
         IDLE: begin
            w_ready  = r_live && !w_full;
            w_accept = cmd.cmd_valid && w_ready;
         end
         EXEC: begin
            w_sample = (r_settle == '0);
         end
         default: ;
      endcase
   end

   // Settle counter and operand registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_live   <= 1'b0;
         r_settle <= '0;
         r_alu_a  <= '0;
         r_alu_b  <= '0;
         r_alu_op <= '0;
         r_tag    <= '0;
      end else begin
         r_live <= 1'b1;
         if (w_accept) begin
            r_settle <= CNTW'(SETTLE - 1);
            r_alu_a  <= cmd.cmd_a;
            r_alu_b  <= cmd.cmd_b;
            r_alu_op <= cmd.cmd_op;
            r_tag    <= cmd.cmd_tag;
         end else if ((r_state == EXEC) && (r_settle != '0)) begin
            r_settle <= r_settle - CNTW'(1);
         end
      end
   end

   assign cmd.cmd_ready = w_ready;
   assign alu.alu_a     = r_alu_a;
   assign alu.alu_b     = r_alu_b;
   assign alu.alu_op    = r_alu_op;

   assign w_push_data.data  = alu.alu_result;
   assign w_push_data.flags = alu.alu_flags;
   assign w_push_data.tag   = r_tag;
   assign w_pop             = res.res_ready && !w_empty;

   valu_result_fifo u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_sample),
      .i_data  (w_push_data),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign res.res_valid = !w_empty;
   assign res.res_data  = w_head.data;
   assign res.res_flags = w_head.flags;
   assign res.res_tag   = w_head.tag;

   // Per-lane pixel view of the head entry
   always_comb begin
      res.res_pixel = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         res.res_pixel[i] = clamp_pixel(w_head.data[i]);
      end
   end

   assign busy = (r_state != IDLE) || (w_count != 2'd0);

endmodule

// File: tb/tb_valu_issue.sv
// Self-checking bench for valu_issue: stub ALU, queue-based reference model for
// the SETTLE=1 instance, directed checks for a SETTLE=3 instance, random traffic.
module tb_valu_issue;
   import valu_pkg::*;

   typedef struct {
      vec_t    data;
      flags_t  flags;
      tag_t    tag;
      pixvec_t pix;
   } ent_t;

   logic clk;
   logic rst_n;
   logic busy1;
   logic busy3;
   logic glitch;
   int   checks = 0;
   int   errors = 0;

   valu_cmd_if cmd1 ();
   valu_alu_if alu1 ();
   valu_res_if res1 ();
   valu_cmd_if cmd3 ();
   valu_alu_if alu3 ();
   valu_res_if res3 ();

   valu_issue #(.SETTLE(1)) u_dut1 (
      .clk(clk), .reset(rst_n), .cmd(cmd1), .alu(alu1), .res(res1), .busy(busy1)
   );
   valu_issue #(.SETTLE(3)) u_dut3 (
      .clk(clk), .reset(rst_n), .cmd(cmd3), .alu(alu3), .res(res3), .busy(busy3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stub ALU: op0 add, op1 sub, else xor; flags {V=0, C=add carry any lane, Z=all zero, N=lane0 msb}
   function automatic vec_t stub_res(vec_t a, vec_t b, op_t op);
      vec_t r;
      for (int i = 0; i < LANES; i++) begin
         case (op)
            3'd0:    r[i] = a[i] + b[i];
            3'd1:    r[i] = a[i] - b[i];
            default: r[i] = a[i] ^ b[i];
         endcase
      end
      return r;
   endfunction

   function automatic flags_t stub_flags(vec_t a, vec_t b, op_t op);
      vec_t       r;
      logic       c;
      logic [W:0] s;
      r = stub_res(a, b, op);
      c = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         s = {1'b0, a[i]} + {1'b0, b[i]};
         if (op == 3'd0) c = c | s[W];
      end
      return {1'b0, c, (r == '0), r[0][W-1]};
   endfunction

   assign alu1.alu_result = stub_res(alu1.alu_a, alu1.alu_b, alu1.alu_op);
   assign alu1.alu_flags  = stub_flags(alu1.alu_a, alu1.alu_b, alu1.alu_op);
   assign alu3.alu_result = glitch ? ~stub_res(alu3.alu_a, alu3.alu_b, alu3.alu_op)
                                   :  stub_res(alu3.alu_a, alu3.alu_b, alu3.alu_op);
   assign alu3.alu_flags  = glitch ? ~stub_flags(alu3.alu_a, alu3.alu_b, alu3.alu_op)
                                   :  stub_flags(alu3.alu_a, alu3.alu_b, alu3.alu_op);

   // Reference model state (SETTLE=1 instance)
   ent_t m_buf[$];
   ent_t m_pend;
   logic m_pend_v = 1'b0;
   int   m_due    = 0;
   logic m_live   = 1'b0;
   vec_t m_alu_a  = '0;
   vec_t m_alu_b  = '0;
   op_t  m_alu_op = '0;
   tag_t popped[$];
   logic last_acc = 1'b0;

   function automatic logic [7:0] pix_of(int unsigned u);
      int s;
      s = (u >= 32'h20000) ? int'(u) - 32'h40000 : int'(u);
      if (s < 0) return 8'd0;
      if (s > 255) return 8'd255;
      return 8'(s);
   endfunction

   // Expected result of a command, using plain integer arithmetic mod 2^18
   function automatic ent_t model_op(vec_t a, vec_t b, op_t op, tag_t tag);
      ent_t        e;
      int unsigned x, y, r;
      logic        carry;
      logic        zero;
      carry = 1'b0;
      zero  = 1'b1;
      for (int i = 0; i < LANES; i++) begin
         x = 32'(a[i]);
         y = 32'(b[i]);
         if (op == 3'd0)      r = x + y;
         else if (op == 3'd1) r = x - y;
         else                 r = x ^ y;
         if ((op == 3'd0) && (r > 32'h3FFFF)) carry = 1'b1;
         r = r & 32'h3FFFF;
         if (r != 0) zero = 1'b0;
         e.data[i] = W'(r);
         e.pix[i]  = pix_of(r);
      end
      e.flags = {1'b0, carry, zero, e.data[0][W-1]};
      e.tag   = tag;
      return e;
   endfunction

   function automatic vec_t mkvec(int l0, int l1, int l2);
      vec_t v;
      v[0] = W'(l0);
      v[1] = W'(l1);
      v[2] = W'(l2);
      return v;
   endfunction

   function automatic pixvec_t mkpix(int p0, int p1, int p2);
      pixvec_t p;
      p[0] = 8'(p0);
      p[1] = 8'(p1);
      p[2] = 8'(p2);
      return p;
   endfunction

   function automatic vec_t rnd_vec();
      vec_t v;
      for (int i = 0; i < LANES; i++) begin
         case ($urandom_range(0, 2))
            0:       v[i] = W'($urandom);
            1:       v[i] = W'(int'($urandom_range(0, 700)) - 350);
            default: v[i] = W'($urandom_range(0, 255));
         endcase
      end
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   // One cycle on the SETTLE=1 instance: compare against model, clock, advance model
   task automatic step1();
      logic exp_ready;
      logic acc;
      logic pop;
      logic rst_at_edge;
      ent_t e;
      exp_ready = m_live && !m_pend_v && (m_buf.size() < 2);
      check("cmd_ready", 64'(cmd1.cmd_ready), 64'(exp_ready));
      check("res_valid", 64'(res1.res_valid), 64'(m_buf.size() != 0));
      check("busy", 64'(busy1), 64'(m_pend_v || (m_buf.size() != 0)));
      check("alu_a", 64'(alu1.alu_a), 64'(m_alu_a));
      check("alu_b", 64'(alu1.alu_b), 64'(m_alu_b));
      check("alu_op", 64'(alu1.alu_op), 64'(m_alu_op));
      if (m_buf.size() != 0) begin
         check("res_data", 64'(res1.res_data), 64'(m_buf[0].data));
         check("res_flags", 64'(res1.res_flags), 64'(m_buf[0].flags));
         check("res_tag", 64'(res1.res_tag), 64'(m_buf[0].tag));
         check("res_pixel", 64'(res1.res_pixel), 64'(m_buf[0].pix));
      end
      rst_at_edge = rst_n;
      acc = rst_at_edge && cmd1.cmd_valid && exp_ready;
      pop = rst_at_edge && res1.res_ready && (m_buf.size() != 0);
      e   = model_op(cmd1.cmd_a, cmd1.cmd_b, cmd1.cmd_op, cmd1.cmd_tag);
      if (pop) popped.push_back(m_buf[0].tag);
      if (acc) begin
         m_alu_a  = cmd1.cmd_a;
         m_alu_b  = cmd1.cmd_b;
         m_alu_op = cmd1.cmd_op;
      end
      @(negedge clk);
      if (!rst_at_edge) begin
         m_buf.delete();
         m_pend_v = 1'b0;
         m_live   = 1'b0;
         m_alu_a  = '0;
         m_alu_b  = '0;
         m_alu_op = '0;
      end else begin
         m_live = 1'b1;
         if (pop) void'(m_buf.pop_front());
         if (m_pend_v) begin
            if (m_due == 1) begin
               m_buf.push_back(m_pend);
               m_pend_v = 1'b0;
            end else begin
               m_due--;
            end
         end
         if (acc) begin
            m_pend   = e;
            m_pend_v = 1'b1;
            m_due    = 1;
         end
      end
      last_acc = acc;
   endtask

   task automatic send1(input vec_t a, input vec_t b, input op_t op, input tag_t tag);
      cmd1.cmd_a     = a;
      cmd1.cmd_b     = b;
      cmd1.cmd_op    = op;
      cmd1.cmd_tag   = tag;
      cmd1.cmd_valid = 1'b1;
      last_acc       = 1'b0;
      for (int n = 0; n < 20 && !last_acc; n++) step1();
      cmd1.cmd_valid = 1'b0;
      check("send_accepted", 64'(last_acc), 64'd1);
   endtask

   task automatic drain1();
      res1.res_ready = 1'b1;
      for (int n = 0; n < 20 && (m_pend_v || (m_buf.size() != 0)); n++) step1();
      check("drain_done", 64'(m_pend_v || (m_buf.size() != 0)), 64'd0);
      res1.res_ready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      ent_t e3;
      vec_t a3;
      vec_t b3;
      rst_n = 1'b0;
      glitch = 1'b0;
      cmd1.cmd_valid = 1'b0; cmd1.cmd_a = '0; cmd1.cmd_b = '0; cmd1.cmd_op = '0; cmd1.cmd_tag = '0;
      cmd3.cmd_valid = 1'b0; cmd3.cmd_a = '0; cmd3.cmd_b = '0; cmd3.cmd_op = '0; cmd3.cmd_tag = '0;
      res1.res_ready = 1'b0;
      res3.res_ready = 1'b0;

      // Reset held for 3 edges: everything zero
      @(negedge clk);
      step1();
      step1();
      check("rst_res_data", 64'(res1.res_data), 64'd0);
      check("rst_res_pixel", 64'(res1.res_pixel), 64'd0);
      check("rst_res_flags", 64'(res1.res_flags), 64'd0);
      check("rst_res_tag", 64'(res1.res_tag), 64'd0);
      check("rst_ready3", 64'(cmd3.cmd_ready), 64'd0);
      check("rst_busy3", 64'(busy3), 64'd0);
      check("rst_valid3", 64'(res3.res_valid), 64'd0);
      check("rst_alu_a3", 64'(alu3.alu_a), 64'd0);
      rst_n = 1'b1;
      step1();
      check("rel_ready1", 64'(cmd1.cmd_ready), 64'd1);
      check("rel_busy1", 64'(busy1), 64'd0);
      check("rel_ready3", 64'(cmd3.cmd_ready), 64'd1);

      // Single add
      send1(mkvec(4, 8, 5), mkvec(4, 2, 10), 3'd0, 4'd3);
      check("t2_valid_early", 64'(res1.res_valid), 64'd0);
      step1();
      check("t2_valid", 64'(res1.res_valid), 64'd1);
      check("t2_data", 64'(res1.res_data), 64'(mkvec(8, 10, 15)));
      check("t2_tag", 64'(res1.res_tag), 64'd3);
      check("t2_flags", 64'(res1.res_flags), 64'h0);
      check("t2_pixel", 64'(res1.res_pixel), 64'(mkpix(8, 10, 15)));
      drain1();

      // Clamp and flags
      send1(mkvec(2010, 300, 350), mkvec(-10, -300, -400), 3'd0, 4'd4);
      step1();
      check("t3_data", 64'(res1.res_data), 64'(mkvec(2000, 0, -50)));
      check("t3_pixel", 64'(res1.res_pixel), 64'(mkpix(255, 0, 0)));
      check("t3_flags", 64'(res1.res_flags), 64'b0100);
      drain1();
      send1(mkvec(5, -7, 0), mkvec(-5, 7, 0), 3'd0, 4'd8);
      step1();
      check("t3z_flags", 64'(res1.res_flags), 64'b0110);
      check("t3z_pixel", 64'(res1.res_pixel), 64'd0);
      drain1();

      // Back-pressure: two fill the buffer, third waits for the first pop
      popped.delete();
      send1(mkvec(1, 2, 3), mkvec(10, 20, 30), 3'd0, 4'd5);
      send1(mkvec(7, 7, 7), mkvec(1, 1, 1), 3'd1, 4'd6);
      cmd1.cmd_a = mkvec(100, 200, 300);
      cmd1.cmd_b = mkvec(5, 5, 5);
      cmd1.cmd_op = 3'd2;
      cmd1.cmd_tag = 4'd7;
      cmd1.cmd_valid = 1'b1;
      repeat (3) step1();
      check("t4_ready_full", 64'(cmd1.cmd_ready), 64'd0);
      check("t4_head_tag", 64'(res1.res_tag), 64'd5);
      check("t4_head_data", 64'(res1.res_data), 64'(mkvec(11, 22, 33)));
      res1.res_ready = 1'b1;
      step1();
      check("t4_ready_after_pop", 64'(cmd1.cmd_ready), 64'd1);
      step1();
      cmd1.cmd_valid = 1'b0;
      drain1();
      check("t4_pop_count", 64'(popped.size()), 64'd3);
      if (popped.size() == 3) begin
         check("t4_pop0", 64'(popped[0]), 64'd5);
         check("t4_pop1", 64'(popped[1]), 64'd6);
         check("t4_pop2", 64'(popped[2]), 64'd7);
      end

      // SETTLE=3 instance: sampling at N+3, mid-window result changes ignored
      a3 = mkvec(100, -3, 250);
      b3 = mkvec(50, 1, 10);
      e3 = model_op(a3, b3, 3'd0, 4'd12);
      cmd3.cmd_a = a3; cmd3.cmd_b = b3; cmd3.cmd_op = 3'd0; cmd3.cmd_tag = 4'd12;
      cmd3.cmd_valid = 1'b1;
      check("t5_ready_pre", 64'(cmd3.cmd_ready), 64'd1);
      @(negedge clk);
      cmd3.cmd_valid = 1'b0;
      check("t5_alu_a", 64'(alu3.alu_a), 64'(a3));
      check("t5_busy", 64'(busy3), 64'd1);
      check("t5_ready_n0", 64'(cmd3.cmd_ready), 64'd0);
      check("t5_valid_n0", 64'(res3.res_valid), 64'd0);
      glitch = 1'b1;
      @(negedge clk);
      check("t5_ready_n1", 64'(cmd3.cmd_ready), 64'd0);
      check("t5_valid_n1", 64'(res3.res_valid), 64'd0);
      @(negedge clk);
      check("t5_ready_n2", 64'(cmd3.cmd_ready), 64'd0);
      check("t5_valid_n2", 64'(res3.res_valid), 64'd0);
      glitch = 1'b0;
      @(negedge clk);
      check("t5_valid_n3", 64'(res3.res_valid), 64'd1);
      check("t5_ready_n3", 64'(cmd3.cmd_ready), 64'd1);
      check("t5_data", 64'(res3.res_data), 64'(e3.data));
      check("t5_flags", 64'(res3.res_flags), 64'(e3.flags));
      check("t5_tag", 64'(res3.res_tag), 64'd12);
      check("t5_pixel", 64'(res3.res_pixel), 64'(e3.pix));
      res3.res_ready = 1'b1;
      @(negedge clk);
      res3.res_ready = 1'b0;
      check("t5_valid_popped", 64'(res3.res_valid), 64'd0);
      check("t5_busy_done", 64'(busy3), 64'd0);

      // Reset one cycle after accept: result discarded
      popped.delete();
      send1(mkvec(9, 9, 9), mkvec(1, 1, 1), 3'd0, 4'd9);
      rst_n = 1'b0;
      step1();
      rst_n = 1'b1;
      res1.res_ready = 1'b1;
      repeat (4) step1();
      check("t6_no_result", 64'(popped.size()), 64'd0);
      check("t6_alu_a_cleared", 64'(alu1.alu_a), 64'd0);
      send1(mkvec(20, 30, 40), mkvec(1, 2, 3), 3'd0, 4'd10);
      drain1();
      check("t6_post_count", 64'(popped.size()), 64'd1);
      if (popped.size() == 1) check("t6_post_tag", 64'(popped[0]), 64'd10);

      // Random traffic against the model
      for (int c = 0; c < 400; c++) begin
         cmd1.cmd_valid = ($urandom_range(0, 9) < 6);
         cmd1.cmd_a     = rnd_vec();
         cmd1.cmd_b     = rnd_vec();
         cmd1.cmd_op    = 3'($urandom_range(0, 3));
         cmd1.cmd_tag   = 4'($urandom);
         res1.res_ready = ($urandom_range(0, 9) < 7);
         step1();
      end
      cmd1.cmd_valid = 1'b0;
      drain1();
      step1();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
